fsm_cpu_sender: RTL and testbench

- CPU-side sender stage that sits directly upstream of the peripheral FSM.
- Buffers 3-bit words written by the CPU core in a small FIFO.
- Transfers each word to the peripheral over a 4-phase send/ack handshake.
- ack comes from the peripheral's clock domain, so this block synchronizes it before use.

---
 rtl/fsm_cpu_sender_pkg.sv | 14 +
 rtl/fsm_cpu_sender_if.sv | 16 +
 rtl/fsm_cpu_sender_sync_ff.sv | 24 ++
 rtl/fsm_cpu_sender.sv | 186 ++++++++++++++++++
 tb/tb_fsm_cpu_sender.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fsm_cpu_sender_pkg.sv
// Shared definitions for the CPU-side sender and the peripheral FSM it feeds:
// the handshake state encoding and the default word width.
package fsm_cpu_pkg;

    // Default transfer width, shared with the peripheral FSM data input.
    localparam int DATA_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/fsm_cpu_sender_if.sv
// Sender <-> peripheral handshake bundle: send/dataOutput go out, ack comes back.
// ack is produced in the peripheral clock domain and is asynchronous to clk1.
interface fsm_cpu_sender_if
    import fsm_cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              send;
    logic [DATA_W-1:0] dataOutput;
    logic              ack;

    modport master (output send, output dataOutput, input ack);
    modport slave  (input send, input dataOutput, output ack);

endinterface

// File: rtl/fsm_cpu_sender_sync_ff.sv
// SYNC_STAGES-deep single-bit synchronizer with asynchronous active-low reset.
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk1,
    input  logic rst1,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Shift the asynchronous input through the flop chain; the last flop is the clean copy.
    always_ff @(posedge clk1 or negedge rst1) begin
        if (!rst1) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/fsm_cpu_sender.sv
// CPU-side sender: queues CPU words in a small FIFO and hands each one to the
// peripheral over a 4-phase send/ack handshake, with ack synchronized into clk1.
// Optional feature macro: ACK_TIMEOUT_EN adds a handshake timeout that drops the
// in-flight word and raises a sticky err flag; without it err is constant 0.
module fsm_cpu_sender
    import fsm_cpu_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int DEPTH          = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk1,
    input  logic                 rst1,
    input  logic                 wr_en,
    input  logic [DATA_W-1:0]    wr_data,
    output logic                 full,
    fsm_cpu_sender_if.master     per,
    output logic                 busy,
    output logic [7:0]           tx_count,
    output logic                 err
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]    CNT_ONE  = 1;
    localparam logic [AW-1:0]  PTR_ONE  = 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fsm_cpu_sender: DEPTH must be a power of 2 and at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("fsm_cpu_sender: SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
        $error("fsm_cpu_sender: TIMEOUT_CYCLES must be at least 1");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              push;
    logic              pop;
    logic              ack_s;
    state_t            state;

    // ack crosses from the peripheral domain; every FSM decision uses ack_s.
    sync_ff #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk1 (clk1),
        .rst1 (rst1),
        .d    (per.ack),
        .q    (ack_s)
    );

    assign full = (count == FULL_CNT);
    assign push = wr_en && !full;
    // The FSM only pops from IDLE and never from an empty FIFO.
    assign pop  = (state == IDLE) && (count != '0);
    assign busy = (state != IDLE) || (count != '0);

    // FIFO storage: data words need no reset, emptiness is tracked by count.
    always_ff @(posedge clk1) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers wrap naturally modulo DEPTH; push and pop may coincide.
    always_ff @(posedge clk1 or negedge rst1) begin
        if (!rst1) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef ACK_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE  = 1;

    logic [TW-1:0] tcnt;

    // Handshake FSM with a watchdog on SEND/RELEASE; a timeout abandons the word.
    always_ff @(posedge clk1 or negedge rst1) begin
        if (!rst1) begin
            state          <= IDLE;
            per.send       <= 1'b0;
            per.dataOutput <= '0;
            tx_count       <= '0;
            tcnt           <= '0;
            err            <= 1'b0;
        end else if (state != IDLE && tcnt == TMO_LAST) begin
            per.send <= 1'b0;
            err      <= 1'b1;
            tcnt     <= '0;
            state    <= IDLE;
        end else begin
            if (state != IDLE) begin
                tcnt <= tcnt + TMO_ONE;
            end
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (pop) begin
                        per.dataOutput <= mem[rd_ptr];
                        per.send       <= 1'b1;
                        state          <= SEND;
                    end
                end
                SEND: begin
                    if (ack_s) begin
                        per.send <= 1'b0;
                        tx_count <= tx_count + 8'd1;
                        state    <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!ack_s) begin
                        tcnt  <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    per.send <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
`else
    assign err = 1'b0;

    // Handshake FSM: pop in IDLE, hold send until ack_s, wait for ack_s to drop.
    always_ff @(posedge clk1 or negedge rst1) begin
        if (!rst1) begin
            state          <= IDLE;
            per.send       <= 1'b0;
            per.dataOutput <= '0;
            tx_count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        per.dataOutput <= mem[rd_ptr];
                        per.send       <= 1'b1;
                        state          <= SEND;
                    end
                end
                SEND: begin
                    if (ack_s) begin
                        per.send <= 1'b0;
                        tx_count <= tx_count + 8'd1;
                        state    <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!ack_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    per.send <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_fsm_cpu_sender.sv
// Self-checking bench for fsm_cpu_sender: queue-based scoreboard of accepted words,
// a peripheral model answering send with programmable ack delays, and random traffic.
module tb_fsm_cpu_sender;
    import fsm_cpu_pkg::*;

    localparam int DW    = 3;
    localparam int DEPTH = 4;
    localparam int SS    = 2;
    localparam int TMO   = 8;

    logic          clk1    = 1'b0;
    logic          rst1    = 1'b0;
    logic          wr_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          full;
    logic          busy;
    logic          err;
    logic [7:0]    tx_count;

    fsm_cpu_sender_if #(.DATA_W(DW)) per_if ();

    fsm_cpu_sender #(
        .DATA_W         (DW),
        .DEPTH          (DEPTH),
        .SYNC_STAGES    (SS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk1     (clk1),
        .rst1     (rst1),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .per      (per_if.master),
        .busy     (busy),
        .tx_count (tx_count),
        .err      (err)
    );

    always #5 clk1 = ~clk1;

    int            checks = 0;
    int            fails  = 0;
    int            cyc    = 0;
    logic [DW-1:0] q [$];
    logic [DW-1:0] dlog [$];
    logic [7:0]    exp_tx  = 8'd0;
    bit            exp_err = 1'b0;
    bit            per_en  = 1'b0;
    bit            tmo_mode = 1'b0;
    bit            send_prev = 1'b0;
    int            up_lo = 0, up_hi = 0, dn_lo = 0, dn_hi = 0;
    int            up_dly = 0, dn_dly = 0;
    int            rise_cyc = -1, fall_cyc = -1, ack_rise = -1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: update the scoreboard from what happened at the edge, run the peripheral model.
    task automatic step();
        bit            acc;
        logic [DW-1:0] wd;
        logic [DW-1:0] h;
        @(posedge clk1);
        acc = rst1 && wr_en && (q.size() < DEPTH);
        wd  = wr_data;
        #1;
        cyc++;
        if (per_if.send && !send_prev) begin
            if (q.size() == 0) begin
                check_val("pop_from_empty", 1, 0);
            end else begin
                h = q.pop_front();
                check_val("data_order", per_if.dataOutput, h);
                dlog.push_back(h);
            end
            if (fall_cyc >= 0) check_val("send_low_gap", (cyc - fall_cyc) >= 2, 1);
            rise_cyc = cyc;
            up_dly   = $urandom_range(up_hi, up_lo);
        end
        if (!per_if.send && send_prev) begin
            fall_cyc = cyc;
            if (tmo_mode) begin
                exp_err = 1'b1;
            end else begin
                exp_tx = exp_tx + 8'd1;
                check_val("ack_to_fall", cyc - ack_rise, SS + 1);
            end
            dn_dly = $urandom_range(dn_hi, dn_lo);
        end
        if (acc) q.push_back(wd);
        send_prev = per_if.send;
        if (per_en) begin
            if (per_if.send && !per_if.ack) begin
                if (up_dly == 0) begin
                    per_if.ack = 1'b1;
                    ack_rise   = cyc;
                end else begin
                    up_dly--;
                end
            end else if (!per_if.send && per_if.ack) begin
                if (dn_dly == 0) per_if.ack = 1'b0;
                else dn_dly--;
            end
        end
        check_val("full", full, q.size() == DEPTH);
        check_val("tx_count", tx_count, exp_tx);
        check_val("err", err, exp_err);
        if (q.size() != 0) check_val("busy_nonempty", busy, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || per_if.ack || per_if.send) && n < budget) begin
            step();
            n++;
        end
        check_val("reach_idle", busy || per_if.ack || per_if.send, 0);
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic set_delays(input int ul, input int uh, input int dl, input int dh);
        up_lo = ul; up_hi = uh; dn_lo = dl; dn_hi = dh;
    endtask

    initial begin
        logic [DW-1:0] exp_burst [5];
        int start;
        per_if.ack = 1'b0;

        // Reset values while rst1 is held low.
        #2;
        check_val("rst_send", per_if.send, 0);
        check_val("rst_data", per_if.dataOutput, 0);
        check_val("rst_full", full, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_tx", tx_count, 0);
        check_val("rst_err", err, 0);
        repeat (2) @(posedge clk1);
        #1 rst1 = 1'b1;

        // Idle after reset with no writes.
        for (int i = 0; i < 20; i++) begin
            step();
            check_val("idle_send", per_if.send, 0);
            check_val("idle_busy", busy, 0);
        end

`ifndef ACK_TIMEOUT_EN
        // Single transfer, ack 3 cycles after send, dropped 2 cycles after send falls.
        per_en = 1'b1;
        set_delays(3, 3, 2, 2);
        write_word(3'b101);
        step();
        check_val("write_to_send", per_if.send, 1);
        wait_idle(100);
        check_val("single_tx", tx_count, 1);
        check_val("single_hold_data", per_if.dataOutput, 3'b101);
        check_val("single_busy", busy, 0);

        // Burst into a stalled sender: full after the 4th queued word, 5th dropped.
        per_en = 1'b0;
        start  = dlog.size();
        write_word(3'b000);
        step();
        check_val("stall_send", per_if.send, 1);
        write_word(3'b001);
        write_word(3'b010);
        write_word(3'b011);
        write_word(3'b100);
        check_val("burst_full", full, 1);
        write_word(3'b111);
        check_val("burst_still_full", full, 1);
        step();
        per_en = 1'b1;
        set_delays(0, 4, 0, 4);
        wait_idle(400);
        exp_burst = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
        check_val("burst_count", dlog.size() - start, 5);
        for (int i = 0; i < 5; i++) begin
            if (start + i < dlog.size()) check_val("burst_word", dlog[start + i], exp_burst[i]);
        end
        check_val("burst_tx", tx_count, 6);

        // Write while a transfer is in SEND with the FIFO otherwise empty.
        set_delays(4, 4, 1, 1);
        start = dlog.size();
        write_word(3'b010);
        step();
        check_val("wdt_in_send", per_if.send, 1);
        check_val("wdt_not_full", full, 0);
        write_word(3'b110);
        wait_idle(200);
        check_val("wdt_count", dlog.size() - start, 2);
        if (dlog.size() >= 1) check_val("wdt_last", dlog[dlog.size() - 1], 3'b110);

        // Random traffic with random ack timing.
        set_delays(0, 4, 0, 4);
        for (int i = 0; i < 400; i++) begin
            wr_en   = ($urandom_range(2, 0) == 0);
            wr_data = DW'($urandom);
            step();
        end
        wr_en = 1'b0;
        wait_idle(400);
        check_val("rand_drained", q.size(), 0);
`else
        // Timeout: ack never arrives for 3'b011, the next word still goes out.
        per_en   = 1'b0;
        tmo_mode = 1'b1;
        write_word(3'b011);
        step();
        check_val("tmo_send", per_if.send, 1);
        for (int i = 0; i < 20 && per_if.send; i++) step();
        check_val("tmo_len", cyc - rise_cyc, TMO);
        check_val("tmo_err", err, 1);
        check_val("tmo_tx", tx_count, 0);
        tmo_mode = 1'b0;
        per_en   = 1'b1;
        set_delays(0, 0, 0, 0);
        write_word(3'b100);
        wait_idle(100);
        if (dlog.size() >= 1) check_val("tmo_next_word", dlog[dlog.size() - 1], 3'b100);
        check_val("tmo_next_tx", tx_count, 1);
        check_val("tmo_err_sticky", err, 1);

        // Random traffic with a prompt peripheral.
        for (int i = 0; i < 300; i++) begin
            wr_en   = ($urandom_range(2, 0) == 0);
            wr_data = DW'($urandom);
            step();
        end
        wr_en = 1'b0;
        wait_idle(400);
        check_val("rand_drained", q.size(), 0);
`endif

        // Reset mid-handshake: send drops without a clock edge, everything clears.
        per_en = 1'b0;
        write_word(3'b101);
        write_word(3'b001);
        write_word(3'b010);
        check_val("pre_rst_send", per_if.send, 1);
        #2 rst1 = 1'b0;
        #1;
        check_val("async_rst_send", per_if.send, 0);
        check_val("async_rst_full", full, 0);
        check_val("async_rst_busy", busy, 0);
        q.delete();
        exp_tx     = 8'd0;
        exp_err    = 1'b0;
        send_prev  = 1'b0;
        fall_cyc   = -1;
        per_if.ack = 1'b0;
        repeat (3) @(posedge clk1);
        #1 rst1 = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check_val("post_rst_tx", tx_count, 0);
        check_val("post_rst_err", err, 0);
        check_val("post_rst_busy", busy, 0);
        check_val("post_rst_send", per_if.send, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
